// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IE/IF registers, IME/EI handling, HALT wake and 5-step dispatch.
// Optional GB_CPU_INT_CANCEL_EN: re-sample the vector index after the PC-high push (IE overwrite cancels).
module gb_cpu_interrupt_ctrl #(
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] irq_req,
  input  logic       ie_wr,
  input  logic       if_wr,
  input  logic [7:0] ie_wdata,
  input  logic [7:0] if_wdata,
  input  logic       ei_req,
  input  logic       di_req,
  input  logic       reti_req,
  input  logic       halt_req,
  input  logic       instr_boundary,
  output logic [7:0] ie_q,
  output logic [7:0] if_q,
  output logic       ime,
  output logic       halted,
  output logic       dispatch_active,
  output logic       push_pc_hi,
  output logic       push_pc_lo,
  output logic       write_interrupt_vector,
  output logic [7:0] interrupt_vector
);

  localparam int unsigned IRQ_W = 5;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT0   = 3'd1,
    WAIT1   = 3'd2,
    PUSH_HI = 3'd3,
    PUSH_LO = 3'd4,
    JUMP    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [IRQ_W-1:0] if_r;
  logic [IRQ_W-1:0] if_nxt;
  logic [7:0]       ie_nxt;
  logic [IRQ_W-1:0] pending;
  logic [IDX_W-1:0] pend_idx;
  logic [IDX_W-1:0] idx_r;
  logic             idx_valid;
  logic             ei_pending;
  logic             start;
  logic [IRQ_W-1:0] clr_mask;
  logic             push_hi_nxt;
  logic             push_lo_nxt;
  logic             write_nxt;
  logic             active_nxt;
  logic [7:0]       vector_nxt;
  logic             unused_if_hi;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [IRQ_W-1:0] v);
    lowest_set = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  assign unused_if_hi = ^if_wdata[7:5];
  assign pending      = ie_q[IRQ_W-1:0] & if_r;
  assign pend_idx     = lowest_set(pending);
  assign start        = (state == IDLE) && instr_boundary && ime && (pending != '0);
  assign if_q         = {3'b111, if_r};

  // Register write data; a request arriving in the same cycle overrides a clearing write or the JUMP ack.
  always_comb begin
    ie_nxt   = ie_wr ? ie_wdata : ie_q;
    clr_mask = '0;
    if (state == JUMP && idx_valid) clr_mask = IRQ_W'(1) << idx_r;
    if_nxt   = ((if_wr ? if_wdata[IRQ_W-1:0] : if_r) & ~clr_mask) | irq_req;
  end

`ifdef GB_CPU_INT_CANCEL_EN
  logic [IRQ_W-1:0] pending_nxt;
  assign pending_nxt = ie_nxt[IRQ_W-1:0] & if_nxt;
`endif

  // Dispatch sequencer: next state and next values of the registered strobes.
  always_comb begin
    state_nxt   = state;
    push_hi_nxt = 1'b0;
    push_lo_nxt = 1'b0;
    write_nxt   = 1'b0;
    active_nxt  = 1'b0;
    vector_nxt  = 8'h00;
    case (state)
      IDLE:    if (start) state_nxt = WAIT0;
      WAIT0:   state_nxt = WAIT1;
      WAIT1:   state_nxt = PUSH_HI;
      PUSH_HI: state_nxt = PUSH_LO;
      PUSH_LO: state_nxt = JUMP;
      JUMP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    active_nxt  = (state_nxt != IDLE);
    push_hi_nxt = (state_nxt == PUSH_HI);
    push_lo_nxt = (state_nxt == PUSH_LO);
    write_nxt   = (state_nxt == JUMP);
    if (state_nxt == JUMP && idx_valid)
      vector_nxt = VECTOR_BASE + 8'({idx_r, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dispatch_active        <= 1'b0;
      push_pc_hi             <= 1'b0;
      push_pc_lo             <= 1'b0;
      write_interrupt_vector <= 1'b0;
      interrupt_vector       <= 8'h00;
    end else begin
      dispatch_active        <= active_nxt;
      push_pc_hi             <= push_hi_nxt;
      push_pc_lo             <= push_lo_nxt;
      write_interrupt_vector <= write_nxt;
      interrupt_vector       <= vector_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ie_q <= 8'h00;
      if_r <= '0;
    end else begin
      ie_q <= ie_nxt;
      if_r <= if_nxt;
    end
  end

  // Vector index: captured at dispatch start, optionally re-sampled as PUSH_HI closes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r     <= '0;
      idx_valid <= 1'b0;
    end else if (start) begin
      idx_r     <= pend_idx;
      idx_valid <= 1'b1;
`ifdef GB_CPU_INT_CANCEL_EN
    end else if (state == PUSH_HI) begin
      idx_r     <= lowest_set(pending_nxt);
      idx_valid <= (pending_nxt != '0);
`endif
    end
  end

  // IME and delayed EI; CPU strobes are ignored while a dispatch is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ime        <= 1'b0;
      ei_pending <= 1'b0;
    end else if (start) begin
      ime        <= 1'b0;
      ei_pending <= 1'b0;
    end else if (state == IDLE) begin
      if (di_req) begin
        ime        <= 1'b0;
        ei_pending <= 1'b0;
      end else begin
        if (reti_req || (ei_pending && instr_boundary)) ime <= 1'b1;
        if (ei_req)              ei_pending <= 1'b1;
        else if (instr_boundary) ei_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                halted <= 1'b0;
    else if (pending != '0)    halted <= 1'b0;
    else if (halt_req)         halted <= 1'b1;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
GB_CPU_INTERRUPT_CTRL -- requirements
Module: gb_cpu_interrupt_ctrl

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 8'h40, the vector of IRQ bit 0; bit n vectors to VECTOR_BASE+8*n.
REQ-002 SHALL have port clk  input  1  machine clock; every state element updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port irq_req  input  5  peripheral request pulses; bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
REQ-005 SHALL have ports ie_wr/if_wr  input  1 each, and ie_wdata/if_wdata  input  8 each, the CPU bus writes to IE (0xFFFF) and IF (0xFF0F).
REQ-006 SHALL have ports ei_req, di_req, reti_req, halt_req  input  1 each, single-cycle decoder strobes.
REQ-007 SHALL have port instr_boundary  input  1  high in the cycle where the next opcode fetch would begin.
REQ-008 SHALL have ports ie_q, if_q  output  8  register readback; if_q = {3'b111, IF[4:0]}.
REQ-009 SHALL have ports ime, halted, dispatch_active  output  1 each, the state flags.
REQ-010 SHALL have ports push_pc_hi, push_pc_lo  output  1 each, stack-push strobes to the sequencer.
REQ-011 SHALL have ports write_interrupt_vector  output  1 and interrupt_vector  output  8, which drive the register file PC-load path.

Function
REQ-012 pending SHALL equal IE[4:0] & IF[4:0]; priority is lowest set bit first.
REQ-013 irq_req[n] SHALL set IF[n] on the next edge; an if_wr in the same cycle loads IF[4:0] = if_wdata[4:0] OR irq_req (request wins).
REQ-014 ie_wr SHALL load all 8 IE bits; if_wdata[7:5] SHALL be ignored.
REQ-015 di_req SHALL clear IME and any pending EI on the next edge; reti_req SHALL set IME on the next edge.
REQ-016 ei_req SHALL arm ei_pending; IME SHALL become 1 at the edge closing the next instr_boundary cycle, never at the edge closing the ei_req cycle.
REQ-017 di_req in the same cycle as ei_req SHALL win (IME=0, ei_pending=0).
REQ-018 FSM states SHALL be IDLE, WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP; each non-IDLE state lasts exactly one cycle, in that order, then IDLE.
REQ-019 IDLE->WAIT0 SHALL occur when instr_boundary & IME & (pending!=0) are true in the same cycle, and only then. ei_pending taking effect at that boundary SHALL NOT start dispatch.
REQ-020 Entry to WAIT0 SHALL clear IME and ei_pending; dispatch_active SHALL be high in every non-IDLE state.
REQ-021 push_pc_hi SHALL be high only in PUSH_HI, and push_pc_lo only in PUSH_LO.
REQ-022 In JUMP, write_interrupt_vector SHALL be 1 and interrupt_vector SHALL be VECTOR_BASE+8*idx; IF[idx] SHALL clear at the edge closing JUMP unless irq_req[idx] is high in that cycle.
REQ-023 interrupt_vector SHALL be 8'h00 outside JUMP.
REQ-024 di_req, ei_req and reti_req SHALL be ignored while dispatch_active is high.
REQ-025 halt_req SHALL set halted; halted SHALL clear the cycle after pending!=0, regardless of IME; halt_req while pending!=0 SHALL leave halted at 0.

Reset
REQ-026 While reset=0 the block SHALL force IE=0, IF=0 (if_q=8'hE0), ime=0, ei_pending=0, halted=0, FSM=IDLE, all strobes=0, interrupt_vector=0.
REQ-027 Reset asserted mid-dispatch SHALL abort the dispatch at the next edge with no IF clear and no vector write.

Configuration
REQ-028 Macro GB_CPU_INT_CANCEL_EN defined: idx SHALL be sampled from pending at the end of PUSH_HI. If pending is 0 at that point, JUMP SHALL drive vector 8'h00 and clear no IF bit. This models the cancellation that occurs when the PC-high push overwrites IE.
REQ-029 Macro GB_CPU_INT_CANCEL_EN undefined: idx SHALL be latched at IDLE->WAIT0 and used unchanged, even if pending later becomes 0.

Verification
REQ-030 IE=01h, IME=1, pulse irq_req[0], then instr_boundary -> push_pc_hi 3 cycles later, then push_pc_lo, then JUMP vector 40h; afterwards if_q=E0h and ime=0.
REQ-031 IE=1Fh, IF=14h, IME=1, boundary -> vector 50h; IF=10h afterwards; a second dispatch gives 60h.
REQ-032 ei_req, then instr_boundary with pending=04h -> no dispatch at that boundary, ime=1; the next boundary dispatches to vector 50h.
REQ-033 With CANCEL_EN: ie_wr=00h during PUSH_HI -> JUMP vector 00h, IF unchanged. Without the macro: vector 40h and IF bit cleared.
REQ-034 halt_req with IME=0, then irq_req[2] with IE=04h -> halted drops the next cycle and no dispatch occurs; reset=0 during WAIT1 -> IDLE, all outputs at reset values.
